rtc_secuenciador: RTL and testbench
===================================

Name: rtc_secuenciador

Overview:
Transaction sequencer for the RTC bus read/write FSM. It scans the RTC time registers periodically, one register per transaction, and arbitrates user write requests onto the same single-transaction interface. It drives iniciar/dir/dir_reg/esc_reg and waits on fin. It sits between the user/control logic and the RTC access FSM.

Parameters:
DIR_BASE, 8'h21, RTC address of the first time register in the scan.
NUM_REG, 6, number of registers per scan (1..15).
PERIODO, 1000000, clk cycles between scan starts (2..2^20).
TIMEOUT, 255, max clk cycles waiting for fin before abort (1..65535).

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-low reset.
req_esc  in  1  user write request; level, held until ack_esc.
dir_esc  in  8  RTC address for the write.
reg_esc  in  4  register selector for the write.
iniciar  out  1  transaction enable to the RTC access FSM.
dir  out  8  RTC address of the current transaction.
dir_reg  out  4  register selector of the current transaction.
esc_reg  out  1  1 = write, 0 = read.
fin  in  1  transaction done from the RTC bus side.
ack_esc  out  1  1-cycle pulse when a write transaction closes.
dato_valido  out  1  1-cycle pulse when a scan read closes.
indice  out  4  scan index of the read that closed; valid with dato_valido.
ciclo_listo  out  1  1-cycle pulse after the last register of a scan closes.
error_to  out  1  1-cycle pulse on fin timeout.
ocupado  out  1  high in every state except REPOSO.

Behaviour:
- Reset (reset=0, async): state=REPOSO; all outputs 0; period counter, timeout counter, scan index and pend_scan cleared. Reset mid-transaction drops iniciar the same instant, and the scan restarts from index 0.
- Period counter counts 0..PERIODO-1 and wraps. The wrap cycle sets pend_scan. A wrap while pend_scan is set or a scan is in progress is dropped, not queued.
- States: REPOSO, CARGA, ESPERA_FIN, LIBERA.
- REPOSO: selection priority is req_esc, then the next scan register (scan in progress or pend_scan), else stay.
  - A new scan clears pend_scan, sets index=0 and takes the index-0 register.
  - Write: dir<=dir_esc, dir_reg<=reg_esc, esc_reg<=1.
  - Read: dir<=DIR_BASE+index (8-bit wrap), dir_reg<=index, esc_reg<=0.
  - Then go to CARGA.
- CARGA: one setup cycle. iniciar stays 0, addresses are stable. Next state is ESPERA_FIN with iniciar<=1 and the timeout counter cleared.
- ESPERA_FIN: iniciar=1; dir/dir_reg/esc_reg held constant.
  - fin sampled 1: go to LIBERA.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT: error_to pulses, and go to LIBERA treating the transaction as closed, but suppress ack_esc/dato_valido for it.
- LIBERA: iniciar<=0 for exactly one cycle, so the access FSM returns to its start state.
  - Write closes: pulse ack_esc.
  - Read closes: pulse dato_valido with indice=index. If index=NUM_REG-1, also pulse ciclo_listo and end the scan. Otherwise index++ and the scan stays in progress.
  - dir/dir_reg/esc_reg return to 0. Next state is REPOSO.
- A write can interleave between scan registers but never inside one. A scan resumes at the next index after the write.
- Minimum transaction length is 4 cycles (REPOSO, CARGA, ESPERA_FIN with fin already 1, LIBERA).
- fin while not in ESPERA_FIN is ignored. req_esc dropped before ack_esc is legal; the write is still completed if already selected.

Test Plan:
- Reset with PERIODO=20, NUM_REG=6, fin never asserted: all outputs 0, ocupado=0. After 20 cycles: CARGA with dir=8'h21, dir_reg=0, esc_reg=0, then iniciar=1.
- fin returned 3 cycles after each iniciar rise: dir steps 21..26, dato_valido ×6 with indice 0..5, then one ciclo_listo. iniciar is low for exactly 1 cycle between transactions.
- req_esc=1, dir_esc=8'h41, reg_esc=4'h3 asserted during scan index 2: index 2 completes, then a write with dir=41, dir_reg=3, esc_reg=1. ack_esc pulses, then the scan resumes at index 3 (dir=24).
- req_esc and period wrap in the same cycle from REPOSO: write served first, scan index 0 next. A second wrap during the scan produces no extra scan.
- TIMEOUT=5, fin held 0: iniciar high for 5 cycles, then error_to pulses, no dato_valido for that register, and the scan advances to the next index.
- reset pulled low in ESPERA_FIN: iniciar=0 asynchronously. After release, the next scan starts at dir=8'h21.

Source files
------------

// File: rtl/rtc_secuenciador.sv
// rtc_secuenciador: sequences single RTC bus transactions. It periodically scans
// NUM_REG time registers starting at DIR_BASE and interleaves user write
// requests between scan registers, handshaking with the access FSM via
// iniciar/fin and aborting on a fin timeout.
module rtc_secuenciador #(
  parameter logic [7:0] DIR_BASE = 8'h21,
  parameter int         NUM_REG  = 6,
  parameter int         PERIODO  = 1000000,
  parameter int         TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_esc,
  input  logic [7:0] dir_esc,
  input  logic [3:0] reg_esc,
  output logic       iniciar,
  output logic [7:0] dir,
  output logic [3:0] dir_reg,
  output logic       esc_reg,
  input  logic       fin,
  output logic       ack_esc,
  output logic       dato_valido,
  output logic [3:0] indice,
  output logic       ciclo_listo,
  output logic       error_to,
  output logic       ocupado
);

  localparam int          PW       = $clog2(PERIODO);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIODO - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  IDX_LAST = 4'(NUM_REG - 1);

  typedef enum logic [1:0] {REPOSO, CARGA, ESPERA_FIN, LIBERA} estado_t;

  estado_t       estado_q, estado_d;
  logic [PW-1:0] per_q, per_d;
  logic          wrap;
  logic [15:0]   to_q, to_d;
  logic [3:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  logic          scan_q, scan_d;
  logic          iniciar_q, iniciar_d;
  logic [7:0]    dir_q, dir_d;
  logic [3:0]    dir_reg_q, dir_reg_d;
  logic          esc_q, esc_d;
  logic          ack_q, ack_d;
  logic          dv_q, dv_d;
  logic [3:0]    indice_q, indice_d;
  logic          listo_q, listo_d;
  logic          err_q, err_d;
  logic          cierre, vencido;

  // Free-running scan period counter; wrap marks the start of a new period.
  always_comb begin
    wrap  = (per_q == PER_LAST);
    per_d = wrap ? '0 : per_q + 1'b1;
  end

  // Next-state and output logic of the transaction FSM.
  always_comb begin
    estado_d  = estado_q;
    to_d      = to_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    scan_d    = scan_q;
    iniciar_d = iniciar_q;
    dir_d     = dir_q;
    dir_reg_d = dir_reg_q;
    esc_d     = esc_q;
    ack_d     = 1'b0;
    dv_d      = 1'b0;
    indice_d  = '0;
    listo_d   = 1'b0;
    err_d     = 1'b0;
    cierre    = 1'b0;
    vencido   = 1'b0;

    // A wrap that arrives while a scan is pending or running is dropped.
    if (wrap && !pend_q && !scan_q) pend_d = 1'b1;

    case (estado_q)
      REPOSO: begin
        if (req_esc) begin
          dir_d     = dir_esc;
          dir_reg_d = reg_esc;
          esc_d     = 1'b1;
          estado_d  = CARGA;
        end else if (scan_q) begin
          dir_d     = DIR_BASE + {4'b0, idx_q};
          dir_reg_d = idx_q;
          esc_d     = 1'b0;
          estado_d  = CARGA;
        end else if (pend_q) begin
          pend_d    = 1'b0;
          scan_d    = 1'b1;
          idx_d     = '0;
          dir_d     = DIR_BASE;
          dir_reg_d = '0;
          esc_d     = 1'b0;
          estado_d  = CARGA;
        end
      end
      CARGA: begin
        iniciar_d = 1'b1;
        to_d      = '0;
        estado_d  = ESPERA_FIN;
      end
      ESPERA_FIN: begin
        if (fin) begin
          cierre = 1'b1;
        end else if (to_q == TO_LAST) begin
          cierre  = 1'b1;
          vencido = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
        // A timed-out transaction still closes and advances the scan,
        // but its completion pulse is suppressed.
        if (cierre) begin
          iniciar_d = 1'b0;
          err_d     = vencido;
          estado_d  = LIBERA;
          if (esc_q) begin
            ack_d = !vencido;
          end else begin
            dv_d     = !vencido;
            indice_d = vencido ? 4'd0 : idx_q;
            if (idx_q == IDX_LAST) begin
              listo_d = 1'b1;
              scan_d  = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      LIBERA: begin
        dir_d     = '0;
        dir_reg_d = '0;
        esc_d     = 1'b0;
        estado_d  = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  // State and output registers; reset drops iniciar immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= REPOSO;
      per_q     <= '0;
      to_q      <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      scan_q    <= 1'b0;
      iniciar_q <= 1'b0;
      dir_q     <= '0;
      dir_reg_q <= '0;
      esc_q     <= 1'b0;
      ack_q     <= 1'b0;
      dv_q      <= 1'b0;
      indice_q  <= '0;
      listo_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      per_q     <= per_d;
      to_q      <= to_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      scan_q    <= scan_d;
      iniciar_q <= iniciar_d;
      dir_q     <= dir_d;
      dir_reg_q <= dir_reg_d;
      esc_q     <= esc_d;
      ack_q     <= ack_d;
      dv_q      <= dv_d;
      indice_q  <= indice_d;
      listo_q   <= listo_d;
      err_q     <= err_d;
    end
  end

  assign iniciar     = iniciar_q;
  assign dir         = dir_q;
  assign dir_reg     = dir_reg_q;
  assign esc_reg     = esc_q;
  assign ack_esc     = ack_q;
  assign dato_valido = dv_q;
  assign indice      = indice_q;
  assign ciclo_listo = listo_q;
  assign error_to    = err_q;
  assign ocupado     = (estado_q != REPOSO);

endmodule

// File: tb/tb_rtc_secuenciador.sv
// Directed bench for rtc_secuenciador with PERIODO=20, NUM_REG=6, TIMEOUT=5.
// A small access-FSM stand-in returns fin 3 cycles after iniciar rises.
module tb_rtc_secuenciador;
  logic       clk = 1'b0;
  logic       reset;
  logic       req_esc;
  logic [7:0] dir_esc;
  logic [3:0] reg_esc;
  logic       iniciar;
  logic [7:0] dir;
  logic [3:0] dir_reg;
  logic       esc_reg;
  logic       fin;
  logic       ack_esc;
  logic       dato_valido;
  logic [3:0] indice;
  logic       ciclo_listo;
  logic       error_to;
  logic       ocupado;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc   = 0;
  int  hi    = 0;
  bit  fin_en = 1'b1;

  rtc_secuenciador #(
    .DIR_BASE(8'h21), .NUM_REG(6), .PERIODO(20), .TIMEOUT(5)
  ) dut (
    .clk(clk), .reset(reset), .req_esc(req_esc), .dir_esc(dir_esc),
    .reg_esc(reg_esc), .iniciar(iniciar), .dir(dir), .dir_reg(dir_reg),
    .esc_reg(esc_reg), .fin(fin), .ack_esc(ack_esc),
    .dato_valido(dato_valido), .indice(indice), .ciclo_listo(ciclo_listo),
    .error_to(error_to), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] allout();
    return 32'({iniciar, dir, dir_reg, esc_reg, ack_esc, dato_valido,
                indice, ciclo_listo, error_to, ocupado});
  endfunction

  // Advance one clock, sample after the edge, and model the fin response.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (iniciar) hi++; else hi = 0;
    fin = fin_en && iniciar && (hi >= 3);
  endtask

  // One full transaction whose CARGA cycle is entered at edge load_cyc.
  task automatic txn(input int load_cyc, input logic [7:0] edir, input logic [3:0] ereg,
                     input logic eesc, input logic [3:0] idx, input bit last,
                     input bit tout, input bit raise_req);
    logic eack, edv, elisto;
    eack   = eesc && !tout;
    edv    = !eesc && !tout;
    elisto = !eesc && last;
    while (cyc < load_cyc - 1) step();
    chk("idle_pre", 32'(ocupado), 32'd0);
    step();
    chk("carga", 32'({ocupado, iniciar, esc_reg, dir_reg, dir}),
        32'({1'b1, 1'b0, eesc, ereg, edir}));
    if (raise_req) req_esc = 1'b1;
    for (int k = 0; k < (tout ? 5 : 3); k++) begin
      step();
      chk("espera", 32'({iniciar, esc_reg, dir_reg, dir, error_to}),
          32'({1'b1, eesc, ereg, edir, 1'b0}));
    end
    step();
    chk("libera", 32'({ocupado, iniciar, ack_esc, dato_valido, ciclo_listo, error_to}),
        32'({1'b1, 1'b0, eack, edv, elisto, tout}));
    if (edv) chk("indice", 32'(indice), 32'(idx));
    if (ack_esc) req_esc = 1'b0;
    step();
    chk("reposo", allout(), 32'd0);
  endtask

  initial begin
    reset = 1'b0; req_esc = 1'b0; dir_esc = 8'h41; reg_esc = 4'h3; fin = 1'b0;
    #2;
    chk("rst_out", allout(), 32'd0);
    repeat (3) begin
      step();
      chk("rst_hold", allout(), 32'd0);
    end
    reset = 1'b1;
    cyc = 0;

    // First scan, with a write requested while index 2 is in flight.
    txn(21, 8'h21, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    txn(27, 8'h22, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    txn(33, 8'h23, 4'd2, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    txn(39, 8'h41, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    txn(45, 8'h24, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    txn(51, 8'h25, 4'd4, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    txn(57, 8'h26, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    // Wraps at 40 and 60 landed inside the scan and must not queue another.
    while (cyc < 80) begin
      step();
      chk("no_extra1", 32'(ocupado), 32'd0);
    end

    // Write request and period wrap seen together in REPOSO: write first.
    req_esc = 1'b1; dir_esc = 8'h55; reg_esc = 4'h7;
    txn(81, 8'h55, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    txn(87,  8'h21, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    txn(93,  8'h22, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    txn(99,  8'h23, 4'd2, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    txn(105, 8'h24, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    txn(111, 8'h25, 4'd4, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    txn(117, 8'h26, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    while (cyc < 140) begin
      step();
      chk("no_extra2", 32'(ocupado), 32'd0);
    end

    // fin never returned for index 0: timeout, then the scan advances.
    fin_en = 1'b0;
    txn(141, 8'h21, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    fin_en = 1'b1;
    txn(149, 8'h22, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);

    // Reset asserted while waiting on fin for index 2.
    while (cyc < 155) step();
    chk("carga_idx2", 32'({ocupado, dir}), 32'({1'b1, 8'h23}));
    step();
    step();
    chk("espera_idx2", 32'(iniciar), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst", allout(), 32'd0);
    step();
    step();
    chk("rst_hold2", allout(), 32'd0);
    reset = 1'b1;
    cyc = 0;
    txn(21, 8'h21, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so a stuck run still ends with a report.
  initial begin
    #20000;
    $display("FAIL timeout: sim did not finish, got cyc %0d want < 2000", cyc);
    $fatal(1);
  end
endmodule
